asr_cmd_decoder: RTL and testbench
==================================

# asr_cmd_decoder

Clocked, parametrised successor to the ASR receive stage. It takes the voice-module result byte and its completion strobe `over`, synchronises the strobe into `clk`, and matches the byte against a run-time-programmable table of `NUM_CMDS` codes. It publishes a sticky 32-bit command word plus a one-cycle valid pulse and a sticky interrupt, with repeat suppression and miss counting. It sits between the ASR UART byte receiver and the AXI-Lite register slave of the ASR_RCV IP.

## Interface
- `CODE_W`, 8: width of the ASR result code.
- `NUM_CMDS`, 4: number of table entries; command word for entry i is i+1.
- `DEF_CODES`, {8'd52,8'd51,8'd50,8'd1}: packed `NUM_CMDS*CODE_W` reset contents; entry 0 is the LSB slice.
- `HOLDOFF`, 1000: cycles during which a repeat of the last accepted command is suppressed; 0 disables suppression.
- `CNT_W`, 16: width of `miss_cnt`.
- `IDX_W`: derived, `$clog2(NUM_CMDS)`, minimum 1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `over` in 1: asynchronous completion strobe; `rcv_msg` is stable while it is high.
- `rcv_msg` in `CODE_W`: result code.
- `tbl_we` in 1: table write enable.
- `tbl_idx` in `IDX_W`: table entry written.
- `tbl_code` in `CODE_W`: code written.
- `irq_clr` in 1: clears `irq`.
- `out_msg` out 32: last accepted command word, sticky.
- `cmd_valid` out 1: one-cycle pulse on acceptance.
- `cmd_idx` out `IDX_W`: index of last accepted entry.
- `irq` out 1: sticky new-command flag.
- `miss_cnt` out `CNT_W`: saturating count of unmatched codes.

## Operation
- **Strobe capture**
  - `over` passes through a 2-FF synchroniser.
  - A rising edge of the synchronised signal is `edge`.
- **FSM states:** IDLE and MATCH.
  - IDLE: on `edge`, `code_q <= rcv_msg` and go to MATCH.
  - MATCH: compare `code_q` with all entries in parallel. The lowest matching index wins. Always return to IDLE after one cycle.
- **Hit handling**
  - Suppressed if `idx+1 == out_msg` and `hold_cnt != 0`. A suppressed hit causes no output change and no miss count.
  - Otherwise: `out_msg <= idx+1`, `cmd_idx <= idx`, `cmd_valid <= 1` for one cycle, `irq <= 1`, and `hold_cnt <= HOLDOFF`.
- **Miss handling:** `miss_cnt` increments and saturates at all-ones. `out_msg` holds its value.
- **Hold-off timer:** `hold_cnt` decrements by 1 each cycle while nonzero.
- **Table writes**
  - A write takes effect the cycle after `tbl_we`.
  - A MATCH in the same cycle as a write uses the old contents.
  - A write with `tbl_idx >= NUM_CMDS` is ignored.
- **`irq` priority:** `irq_clr` clears `irq`. If a set and `irq_clr` occur in the same cycle, the set wins.

## Timing
- **Reset values:** `out_msg`=0, `cmd_valid`=0, `cmd_idx`=0, `irq`=0, `miss_cnt`=0, `hold_cnt`=0, FSM=IDLE, synchroniser=0, table=`DEF_CODES`.
- **Reset mid-operation:** an in-flight MATCH is discarded, and the table reloads its defaults.
- **Latency**
  - `over` rises before clk edge 0.
  - `edge` is high in cycle 2 and `code_q` is captured at the end of cycle 2.
  - MATCH occurs in cycle 3.
  - `out_msg`, `cmd_valid` and `irq` are visible in cycle 4.
- **Strobe spacing:** `edge` pulses are at least 2 cycles apart, so MATCH never overlaps a new `edge`. The FSM drops no strobes.
- **Level behaviour:** `over` held high produces one event only; a new event requires `over` low for at least 2 cycles.
- **Hold-off window:** suppression covers `HOLDOFF` cycles after the acceptance cycle. A different command is accepted at any time and restarts the timer.

## Structure
- Package `asr_pkg` holds:
  - the `asr_state_t` enum (IDLE, MATCH);
  - the default code constants 1, 50, 51, 52 (small-step, humidity, temperature, curtain);
  - the `CNT_W` default.
- One sub-module, `asr_sync_edge`: 2-FF synchroniser plus rising-edge detector. Inputs are `clk`, `rst_n` and async `din`; output is the `rise` pulse.
- The table, comparator, FSM, timer and counters live in `asr_cmd_decoder`.

## Test plan
- **Default decode:** after reset, pulse `over` with `rcv_msg`=50 → `out_msg`=2 four cycles later, `cmd_valid` high for exactly one cycle, `irq`=1, `cmd_idx`=1.
- **Miss:** `rcv_msg`=7 → `out_msg` holds its previous value, `miss_cnt` goes 0→1. Force `miss_cnt` to all-ones, send another miss → it stays all-ones.
- **Repeat suppression (`HOLDOFF`=10)**
  - Send code 1 twice, 5 cycles apart → only one `cmd_valid`.
  - Send code 1 again 12 cycles after acceptance → second `cmd_valid`.
  - Send code 51 within the window → accepted, `out_msg`=3.
- **Table reprogram**
  - Write entry 3 = 0x80 → code 0x80 yields `out_msg`=4 and code 52 counts as a miss.
  - Write to `tbl_idx`=3 with `NUM_CMDS`=3 → no effect.
  - Write in the same cycle as MATCH → old contents used.
- **irq and reset**
  - `irq_clr` in the same cycle as an acceptance → `irq` stays 1.
  - `over` held high for 100 cycles → exactly one event.
  - Assert `rst_n` low during MATCH → all outputs return to reset values and the table returns to its defaults.

Source files
------------

// File: rtl/asr_pkg.sv
// asr_pkg: shared types and constants for the ASR command decoder.
// Default result codes of the voice module and the FSM state type.
package asr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        MATCH = 1'b1
    } asr_state_t;

    localparam logic [7:0] CODE_SMALL_STEP  = 8'd1;
    localparam logic [7:0] CODE_HUMIDITY    = 8'd50;
    localparam logic [7:0] CODE_TEMPERATURE = 8'd51;
    localparam logic [7:0] CODE_CURTAIN     = 8'd52;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/asr_cmd_decoder_sync.sv
// asr_sync_edge: 2-FF synchroniser for the async strobe plus a
// registered rising-edge detector producing a one-cycle pulse.
module asr_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_q;

    // shift the strobe through two sync stages and one history stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/asr_cmd_decoder.sv
// asr_cmd_decoder: matches ASR result codes against a programmable
// table and publishes a sticky command word, valid pulse and irq.
module asr_cmd_decoder
    import asr_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int NUM_CMDS = 4,
    parameter logic [NUM_CMDS*CODE_W-1:0] DEF_CODES =
        {CODE_CURTAIN, CODE_TEMPERATURE, CODE_HUMIDITY, CODE_SMALL_STEP},
    parameter int HOLDOFF = 1000,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              over,
    input  logic [CODE_W-1:0] rcv_msg,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic              irq_clr,
    output logic [31:0]       out_msg,
    output logic              cmd_valid,
    output logic [IDX_W-1:0]  cmd_idx,
    output logic              irq,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    logic              rise_w;
    asr_state_t        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] tbl_q [NUM_CMDS];

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [31:0]       hit_cmd;
    logic              suppress;
    logic              accept;
    logic              miss;

    logic [31:0]       out_msg_q, out_msg_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [IDX_W-1:0]  cmd_idx_q, cmd_idx_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    asr_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (over),
        .rise  (rise_w)
    );

    // code table: defaults on reset, run-time writes to valid entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CMDS; i++) begin
                tbl_q[i] <= DEF_CODES[i*CODE_W +: CODE_W];
            end
        end else if (tbl_we && (int'(tbl_idx) < NUM_CMDS)) begin
            tbl_q[tbl_idx] <= tbl_code;
        end
    end

    // parallel compare; scanning downwards lets the lowest index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (tbl_q[i] == code_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_cmd  = 32'(hit_idx) + 32'd1;
    assign suppress = (hit_cmd == out_msg_q) && (hold_q != '0);

    // FSM state and captured code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // FSM next state: capture on strobe edge, decide in MATCH
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        accept  = 1'b0;
        miss    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise_w) begin
                    code_d  = rcv_msg;
                    state_d = MATCH;
                end
            end
            MATCH: begin
                state_d = IDLE;
                if (!hit) begin
                    miss = 1'b1;
                end else if (!suppress) begin
                    accept = 1'b1;
                end
            end
        endcase
    end

    // output, interrupt, miss counter and hold-off next values
    always_comb begin
        out_msg_d   = out_msg_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_valid_d = accept;
        irq_d       = irq_q;
        miss_d      = miss_q;
        hold_d      = hold_q;
        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (accept) begin
            out_msg_d = hit_cmd;
            cmd_idx_d = hit_idx;
            irq_d     = 1'b1;
            hold_d    = HOLD_LOAD;
        end
        if (miss && (miss_q != '1)) begin
            miss_d = miss_q + CNT_W'(1);
        end
    end

    // registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_msg_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_idx_q   <= '0;
            irq_q       <= 1'b0;
            miss_q      <= '0;
            hold_q      <= '0;
        end else begin
            out_msg_q   <= out_msg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_idx_q   <= cmd_idx_d;
            irq_q       <= irq_d;
            miss_q      <= miss_d;
            hold_q      <= hold_d;
        end
    end

    assign out_msg   = out_msg_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_idx   = cmd_idx_q;
    assign irq       = irq_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_asr_cmd_decoder.sv
// tb_asr_cmd_decoder: directed scoreboard bench for asr_cmd_decoder.
// Instance a: 4 entries, short hold-off; instance b: 3 entries.
module tb_asr_cmd_decoder;

    typedef struct {
        logic [31:0] msg;
        logic [31:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_b;
    logic        over;
    logic [7:0]  rcv_msg;
    logic        tbl_we, tbl_we_b;
    logic [1:0]  tbl_idx, tbl_idx_b;
    logic [7:0]  tbl_code;
    logic        irq_clr;

    logic [31:0] out_msg, b_out_msg;
    logic        cmd_valid, b_cmd_valid;
    logic [1:0]  cmd_idx, b_cmd_idx;
    logic        irq, b_irq;
    logic [2:0]  miss_cnt;
    logic [3:0]  b_miss_cnt;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    asr_cmd_decoder #(
        .CODE_W(8), .NUM_CMDS(4),
        .DEF_CODES({8'd52, 8'd51, 8'd50, 8'd1}),
        .HOLDOFF(10), .CNT_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .over(over), .rcv_msg(rcv_msg),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_code(tbl_code),
        .irq_clr(irq_clr), .out_msg(out_msg), .cmd_valid(cmd_valid),
        .cmd_idx(cmd_idx), .irq(irq), .miss_cnt(miss_cnt)
    );

    asr_cmd_decoder #(
        .CODE_W(8), .NUM_CMDS(3),
        .DEF_CODES({8'd51, 8'd50, 8'd1}),
        .HOLDOFF(10), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .over(over), .rcv_msg(rcv_msg),
        .tbl_we(tbl_we_b), .tbl_idx(tbl_idx_b), .tbl_code(tbl_code),
        .irq_clr(irq_clr), .out_msg(b_out_msg), .cmd_valid(b_cmd_valid),
        .cmd_idx(b_cmd_idx), .irq(b_irq), .miss_cnt(b_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] msg, input logic [31:0] idx);
        exp_t e;
        e.msg = msg;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // one strobe; optional table write / irq_clr during the MATCH cycle
    task automatic pulse(input logic [7:0] code,
                         input logic wr = 1'b0,
                         input logic [1:0] widx = 2'd0,
                         input logic [7:0] wcode = 8'd0,
                         input logic clr = 1'b0);
        rcv_msg = code;
        over = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        over = 1'b0;
        tbl_we = wr;
        tbl_idx = widx;
        tbl_code = wcode;
        irq_clr = clr;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        irq_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every acceptance pulse must match the queue head
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            n_chk++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_valid: observed out_msg=%0h expected no acceptance",
                       out_msg);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_out_msg", out_msg, e.msg);
                chk("sb_cmd_idx", 32'(cmd_idx), e.idx);
                chk("sb_irq", 32'(irq), 32'd1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        over = 1'b0;
        rcv_msg = '0;
        tbl_we = 1'b0;
        tbl_we_b = 1'b0;
        tbl_idx = '0;
        tbl_idx_b = '0;
        tbl_code = '0;
        irq_clr = 1'b0;
        idle(3);
        chk("rst_out_msg", out_msg, 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_idx", 32'(cmd_idx), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        idle(2);

        // default decode with latency check
        push(32'd2, 32'd1);
        rcv_msg = 8'd50;
        over = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        over = 1'b0;
        @(negedge clk);
        chk("lat_before", 32'(cmd_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", 32'(cmd_valid), 32'd1);
        chk("dec_out_msg", out_msg, 32'd2);
        chk("dec_cmd_idx", 32'(cmd_idx), 32'd1);
        chk("dec_irq", 32'(irq), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("valid_one_cycle", 32'(cmd_valid), 32'd0);
        idle(1);

        // miss
        pulse(8'd7);
        chk("miss_out_hold", out_msg, 32'd2);
        chk("miss_cnt_1", 32'(miss_cnt), 32'd1);

        // irq_clr alone
        irq_clr = 1'b1;
        idle(1);
        irq_clr = 1'b0;
        chk("irq_clr", 32'(irq), 32'd0);

        // repeat suppression
        push(32'd1, 32'd0);
        pulse(8'd1);
        pulse(8'd1);
        idle(2);
        push(32'd1, 32'd0);
        pulse(8'd1);
        push(32'd3, 32'd2);
        pulse(8'd51);
        idle(3);
        chk("supp_drain", 32'(exp_q.size()), 32'd0);
        chk("supp_out_msg", out_msg, 32'd3);

        // table reprogram; b gets an out-of-range write
        rst_n_b = 1'b0;
        idle(1);
        rst_n_b = 1'b1;
        tbl_we = 1'b1;
        tbl_we_b = 1'b1;
        tbl_idx = 2'd3;
        tbl_idx_b = 2'd3;
        tbl_code = 8'h80;
        idle(1);
        tbl_we = 1'b0;
        tbl_we_b = 1'b0;
        push(32'd4, 32'd3);
        pulse(8'h80);
        chk("prog_out_msg", out_msg, 32'd4);
        chk("b_oor_out_msg", b_out_msg, 32'd0);
        chk("b_oor_miss", 32'(b_miss_cnt), 32'd1);
        pulse(8'd52);
        chk("old_code_miss", 32'(miss_cnt), 32'd2);
        chk("old_code_hold", out_msg, 32'd4);

        // write and irq_clr in the MATCH cycle: old table, set wins
        push(32'd2, 32'd1);
        pulse(8'd50, 1'b1, 2'd1, 8'h11, 1'b1);
        chk("same_cyc_out", out_msg, 32'd2);
        chk("same_cyc_irq", 32'(irq), 32'd1);
        pulse(8'd50);
        chk("new_entry_miss", 32'(miss_cnt), 32'd3);
        chk("new_entry_hold", out_msg, 32'd2);

        // saturation
        for (int i = 0; i < 4; i++) pulse(8'd7);
        chk("miss_sat_reach", 32'(miss_cnt), 32'd7);
        pulse(8'd7);
        chk("miss_sat_stay", 32'(miss_cnt), 32'd7);

        // over held high
        push(32'd3, 32'd2);
        rcv_msg = 8'd51;
        over = 1'b1;
        idle(100);
        over = 1'b0;
        idle(5);
        chk("level_drain", 32'(exp_q.size()), 32'd0);
        chk("level_out", out_msg, 32'd3);

        // reset during MATCH
        rcv_msg = 8'd52;
        over = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        over = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_out_msg", out_msg, 32'd0);
        chk("mrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("mrst_cmd_idx", 32'(cmd_idx), 32'd0);
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_miss_cnt", 32'(miss_cnt), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("mrst_discard", out_msg, 32'd0);
        push(32'd2, 32'd1);
        pulse(8'd50);
        push(32'd4, 32'd3);
        pulse(8'd52);
        idle(3);
        chk("mrst_tbl_out", out_msg, 32'd4);
        chk("mrst_miss_zero", 32'(miss_cnt), 32'd0);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
